// File: rtl/gray_encoder_stream.sv
// Binary-to-Gray encoder with a 2-entry output FIFO, adjacency flag and
// an optional free-running counter source for continuous Gray sequences.
module gray_encoder_stream #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_bin,
   input  logic             cnt_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_gray,
   output logic             out_adj,
   output logic [CNT_W-1:0] tx_count
);

   // Handshakes: a word moves on a rising edge where valid && ready are both
   // high; valid never depends on ready, and in_ready never depends on out_ready.

   logic [WIDTH-1:0] mem [2];
   logic             head;
   logic             tail;
   logic [1:0]       count;
   logic             mode_q;
   logic [WIDTH-1:0] ctr;
   logic [WIDTH-1:0] last_sent;
   logic [CNT_W-1:0] tx_cnt_q;

   logic             src_valid;
   logic [WIDTH-1:0] src_word;
   logic [WIDTH-1:0] src_gray;
   logic             not_full;
   logic             push;
   logic             pop;

   function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] g;
      g[WIDTH-1] = b[WIDTH-1];
      for (int i = 0; i < WIDTH - 1; i++) begin
         g[i] = b[i+1] ^ b[i];
      end
      return g;
   endfunction

   function automatic int unsigned popcount(input logic [WIDTH-1:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < WIDTH; i++) begin
         n = n + int'(v[i]);
      end
      return n;
   endfunction

   // The registered mode selects the source, so a cnt_mode change is seen one cycle later.
   always_comb begin
      src_valid = in_valid;
      src_word  = in_bin;
      if (mode_q) begin
         src_valid = 1'b1;
         src_word  = ctr;
      end
   end

   assign src_gray  = bin_to_gray(src_word);
   assign not_full  = (count != 2'd2);
   assign push      = src_valid && not_full;
   assign out_valid = (count != 2'd0);
   assign pop       = out_valid && out_ready;
   assign in_ready  = !mode_q && not_full;
   assign out_gray  = out_valid ? mem[head] : '0;
   assign out_adj   = out_valid && (popcount(out_gray ^ last_sent) == 1);
   assign tx_count  = tx_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         head   <= 1'b0;
         tail   <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[tail] <= src_gray;
            tail      <= ~tail;
         end
         if (pop) begin
            head <= ~head;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q    <= 1'b0;
         ctr       <= '0;
         last_sent <= '0;
         tx_cnt_q  <= '0;
      end else begin
         mode_q <= cnt_mode;
         if (mode_q && push) begin
            ctr <= ctr + WIDTH'(1);
         end
         if (pop) begin
            last_sent <= mem[head];
            tx_cnt_q  <= tx_cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: doc/gray_encoder_stream.md
Name: gray_encoder_stream

Overview:
- Binary-to-Gray encoder for the Hamming/Gray datapath on the Tang 9K; the transmit-side counterpart of the Gray-to-binary decoder.
- Accepts binary words over a valid/ready handshake and buffers the encoded Gray words in a 2-entry FIFO.
- Presents the Gray words downstream with an adjacency (single-bit-step) flag.
- Optional internal counter mode generates a continuous Gray sequence for LED/test use.

Parameters:
WIDTH, 4, word width in bits (Gray and binary).
CNT_W, 8, width of the transmitted-word counter.

Ports:
clk  input  1  system clock, all state on rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  in_bin holds a word to encode.
in_ready  output  1  block can accept a word this cycle.
in_bin  input  WIDTH  binary word, b[WIDTH-1] is MSB.
cnt_mode  input  1  1 = internal counter is the source; in_* ignored.
out_valid  output  1  out_gray holds a word.
out_ready  input  1  downstream accepts the word this cycle.
out_gray  output  WIDTH  Gray word at FIFO head.
out_adj  output  1  1 if out_gray differs from the last transmitted word in exactly one bit.
tx_count  output  CNT_W  number of completed output handshakes, wraps.

Behaviour:
- Reset is asynchronous and active-high.
  - Values while rst=1 and after release: FIFO empty (count=0), out_valid=0, out_gray=0, last_sent=0, counter=0, tx_count=0, in_ready=1.
  - Reset asserted mid-operation flushes all buffered words immediately; nothing in flight is preserved.
- Encoding rules:
  - g[WIDTH-1] = b[WIDTH-1].
  - g[i] = b[i+1] ^ b[i] for i < WIDTH-1.
  - Encoding is done on push; the FIFO stores Gray words.
- FIFO: 2 entries, occupancy count 0..2, head/tail pointers wrap mod 2.
  - out_valid = (count != 0).
  - out_gray = head entry, or 0 when empty.
- Push and pop conditions:
  - push = src_valid && (count < 2).
  - pop = out_valid && out_ready.
  - No pass-through when full: at count=2, in_ready=0 even if out_ready=1.
  - Simultaneous push and pop: count is unchanged and both pointers advance.
- Source select, state is cnt_mode:
  - cnt_mode=0: src_valid = in_valid, src word = in_bin, in_ready = (count < 2).
  - cnt_mode=1: in_ready=0, src_valid=1, src word = internal binary counter.
    - Counter increments by 1 on each push and wraps from 2^WIDTH-1 to 0.
    - Counter holds its value when cnt_mode=0.
- Mode switching:
  - A mode change takes effect on the next cycle.
  - Words already in the FIFO drain unchanged in order; no flush.
- Latency: a word accepted at edge N appears on out_gray after edge N (1 cycle) if the FIFO was empty; otherwise it appears behind the older entries.
- Throughput: 1 word per cycle when out_ready is held high.
- Adjacency flag:
  - last_sent updates to out_gray on each pop.
  - out_adj = out_valid && (popcount(out_gray ^ last_sent) == 1).
  - An identical repeated word gives out_adj=0.
- tx_count increments by 1 on each pop and wraps at 2^CNT_W.
- All outputs are driven from registers or from simple combinational decode of the count/head; no combinational path from out_ready to in_ready.

Test Plan:
- Reset: assert rst mid-stream with 2 words buffered -> out_valid=0, out_gray=0, tx_count=0, in_ready=1 while rst=1 and after release.
- Encoding with out_ready=1:
  - push 5 -> out_gray=0111 one cycle later.
  - Subsequent pushes 10, 15, 8, 3 -> 1111, 1000, 1100, 0010 in order.
  - tx_count=5 at the end.
- Backpressure with out_ready=0:
  - push 1 and 2 -> in_ready=0 after the second push; third word 4 is not accepted.
  - Raise out_ready -> 0001, 0011, then (after 4 is re-presented) 0110; no loss and no duplication.
- Simultaneous push and pop at count=1 for 10 cycles -> count stays 1, outputs in order, one word per cycle.
- Counter mode:
  - cnt_mode=1, out_ready=1 for 17 cycles -> Gray sequence 0000, 0001, 0011, 0010, ..., 1000, 0000 (wrap).
  - out_adj=1 on every word after the first.
  - in_ready=0 throughout.
- Adjacency check in cnt_mode=0:
  - send 3 then 3 again -> out_adj=0 on the second word.
  - send 0 then 5 -> out_adj=0 (0000 -> 0111).
  - send 4 then 5 -> out_adj=1 (0110 -> 0111).
